// File: rtl/mips_pkg.sv
// Shared MIPS control definitions: opcodes, ALU function codes, PC source
// selects and the multi-cycle state encoding.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] ALU_ADD  = 6'b100000;
  localparam logic [5:0] ALU_SUB  = 6'b100010;

  localparam logic [1:0] PCSRC_INC    = 2'd0;
  localparam logic [1:0] PCSRC_BRANCH = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    FAULT  = 3'd5
  } state_t;

  // True for every opcode the sequencer knows how to execute.
  function automatic logic op_legal(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J: op_legal = 1'b1;
      default:                                       op_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Memory wait counter: counts consecutive not-ready cycles while the FSM sits
// in a memory state and flags a timeout on the TIMEOUT-th such cycle.
// TIMEOUT = 0 disables the timeout.
module mc_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic active,
  input  logic mem_ready,
  output logic timeout
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;

  // Every memory state is left on mem_ready (or on timeout, which drops
  // active), so clearing on ready/inactive gives a zero count on entry.
  always_ff @(posedge clk) begin
    if (reset || !active || mem_ready) cnt <= '0;
    else                               cnt <= cnt + 1'b1;
  end

  assign timeout = (TIMEOUT != 0) && active && !mem_ready && (cnt == LAST);

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control unit. Latches the fetched instruction and steps
// it through FETCH/DECODE/EXEC/MEM/WB, driving datapath strobes as Mealy
// outputs of the state register and IR. Illegal opcodes and memory
// timeouts park the FSM in FAULT until reset.
module multicycle_control
  import mips_pkg::*;
#(
  parameter int FUNC_W  = 6,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  input  logic              zero,
  output logic              pc_write,
  output logic              ir_write,
  output logic              iord,
  output logic [1:0]        pc_src,
  output logic              reg_write,
  output logic              mem_to_reg,
  output logic              mem_write,
  output logic              mem_read,
  output logic              alu_src,
  output logic              reg_dst,
  output logic [FUNC_W-1:0] alu_func,
  output logic              fault,
  output logic [CNT_W-1:0]  retired
);

  state_t             state;
  logic [31:0]        ir;
  logic [CNT_W-1:0]   ret_cnt;
  logic               tmo;
  logic               waiting;
  logic [5:0]         op;
  logic [5:0]         funct;
  logic               ir_unused;

  assign op        = ir[31:26];
  assign funct     = ir[5:0];
  assign ir_unused = ^ir[25:6];
  assign waiting   = (state == FETCH) || (state == MEM);

  mc_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk       (clk),
    .reset     (reset),
    .active    (waiting),
    .mem_ready (mem_ready),
    .timeout   (tmo)
  );

  // State sequencing, IR capture and retired-instruction counting.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= FETCH;
      ir      <= '0;
      ret_cnt <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (mem_ready) begin
            ir    <= mem_rdata;
            state <= DECODE;
          end else if (tmo) begin
            state <= FAULT;
          end
        end
        DECODE: begin
          if (op == OP_J) begin
            state   <= FETCH;
            ret_cnt <= ret_cnt + 1'b1;
          end else if (!op_legal(op)) begin
            state <= FAULT;
          end else begin
            state <= EXEC;
          end
        end
        EXEC: begin
          case (op)
            OP_BEQ: begin
              state   <= FETCH;
              ret_cnt <= ret_cnt + 1'b1;
            end
            OP_LW, OP_SW: state <= MEM;
            default:      state <= WB;
          endcase
        end
        MEM: begin
          if (mem_ready) begin
            if (op == OP_SW) begin
              state   <= FETCH;
              ret_cnt <= ret_cnt + 1'b1;
            end else begin
              state <= WB;
            end
          end else if (tmo) begin
            state <= FAULT;
          end
        end
        WB: begin
          state   <= FETCH;
          ret_cnt <= ret_cnt + 1'b1;
        end
        default: state <= FAULT;
      endcase
    end
  end

  // Strobe decode; everything is held low while reset is asserted.
  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    iord       = 1'b0;
    pc_src     = PCSRC_INC;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    mem_write  = 1'b0;
    mem_read   = 1'b0;
    alu_src    = 1'b0;
    reg_dst    = 1'b0;
    alu_func   = '0;
    fault      = 1'b0;
    if (!reset) begin
      case (state)
        FETCH: begin
          mem_read = 1'b1;
          ir_write = mem_ready;
          pc_write = mem_ready;
        end
        DECODE: begin
          if (op == OP_J) begin
            pc_write = 1'b1;
            pc_src   = PCSRC_JUMP;
          end
        end
        EXEC: begin
          case (op)
            OP_RTYPE: alu_func = FUNC_W'(funct);
            OP_ADDI, OP_LW, OP_SW: begin
              alu_src  = 1'b1;
              alu_func = FUNC_W'(ALU_ADD);
            end
            OP_BEQ: begin
              alu_func = FUNC_W'(ALU_SUB);
              pc_src   = PCSRC_BRANCH;
              pc_write = zero;
            end
            default: ;
          endcase
        end
        MEM: begin
          iord      = 1'b1;
          alu_src   = 1'b1;
          alu_func  = FUNC_W'(ALU_ADD);
          mem_read  = (op == OP_LW);
          mem_write = (op == OP_SW);
        end
        WB: begin
          reg_write  = 1'b1;
          reg_dst    = (op == OP_RTYPE);
          mem_to_reg = (op == OP_LW);
        end
        FAULT:   fault = 1'b1;
        default: ;
      endcase
    end
  end

  assign retired = reset ? '0 : ret_cnt;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control. A per-instruction reference model
// expands each instruction into its expected cycle-by-cycle strobe pattern
// and pushes it to a queue; a negedge monitor pops and compares.
module tb_multicycle_control;

  localparam int TMO = 4;
  localparam int CW  = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   mem_rdata;
  logic          mem_ready;
  logic          zero;
  logic          pc_write, ir_write, iord;
  logic [1:0]    pc_src;
  logic          reg_write, mem_to_reg, mem_write, mem_read, alu_src, reg_dst;
  logic [5:0]    alu_func;
  logic          fault;
  logic [CW-1:0] retired;

  always #5 clk = ~clk;

  multicycle_control #(.FUNC_W(6), .TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .zero       (zero),
    .pc_write   (pc_write),
    .ir_write   (ir_write),
    .iord       (iord),
    .pc_src     (pc_src),
    .reg_write  (reg_write),
    .mem_to_reg (mem_to_reg),
    .mem_write  (mem_write),
    .mem_read   (mem_read),
    .alu_src    (alu_src),
    .reg_dst    (reg_dst),
    .alu_func   (alu_func),
    .fault      (fault),
    .retired    (retired)
  );

  typedef struct packed {
    logic       pcw, irw, iord;
    logic [1:0] pcs;
    logic       rw, m2r, mw, mr, as, rd;
    logic [5:0] fn;
    logic       flt;
  } strb_t;

  typedef struct packed {
    strb_t         s;
    logic [CW-1:0] ret;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          e;
  strb_t         act;
  int            checks = 0;
  int            failures = 0;
  int            ncyc = 0;
  logic [CW-1:0] ret_m;

  always_comb act = {pc_write, ir_write, iord, pc_src, reg_write, mem_to_reg,
                     mem_write, mem_read, alu_src, reg_dst, alu_func, fault};

  // Monitor: one expected record per clock cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (act !== e.s) begin
        failures++;
        $display("FAIL strobes cyc=%0d got=%h exp=%h", ncyc, act, e.s);
      end
      checks++;
      if (retired !== e.ret) begin
        failures++;
        $display("FAIL retired cyc=%0d got=%0d exp=%0d", ncyc, retired, e.ret);
      end
      ncyc++;
    end
  end

  function automatic logic rb();
    return 1'($urandom & 1);
  endfunction

  // Drive one cycle of inputs and queue what the outputs must be.
  task automatic cyc(input logic rst, input logic rdy, input logic z,
                     input logic [31:0] rd, input strb_t s);
    exp_t x;
    reset = rst; mem_ready = rdy; zero = z; mem_rdata = rd;
    x.s = s;
    x.ret = rst ? '0 : ret_m;
    exp_q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    cyc(1'b1, rb(), rb(), $urandom, '0);
    ret_m = '0;
  endtask

  // Faulted unit: fault high, strobes low regardless of inputs, until reset.
  task automatic fault_tail(input int n);
    strb_t s;
    s = '0; s.flt = 1'b1;
    for (int i = 0; i < n; i++) cyc(1'b0, rb(), rb(), $urandom, s);
    do_reset();
  endtask

  // Reference model for one instruction. fw/mw are wait cycles before ready
  // in fetch/mem; TMO or more waits is a timeout. rst_mem aborts in MEM.
  task automatic run_instr(input logic [31:0] ins, input int fw, input int mw,
                           input logic z, input logic rst_mem);
    strb_t s;
    logic [5:0] op;
    op = ins[31:26];
    for (int i = 0; i < fw && i < TMO; i++) begin
      s = '0; s.mr = 1'b1;
      cyc(1'b0, 1'b0, rb(), $urandom, s);
    end
    if (fw >= TMO) begin fault_tail(3); return; end
    s = '0; s.mr = 1'b1; s.irw = 1'b1; s.pcw = 1'b1;
    cyc(1'b0, 1'b1, rb(), ins, s);

    s = '0;
    if (op == 6'h02) begin
      s.pcw = 1'b1; s.pcs = 2'd2;
      cyc(1'b0, rb(), rb(), $urandom, s);
      ret_m++;
      return;
    end
    cyc(1'b0, rb(), rb(), $urandom, s);
    if (!(op inside {6'h00, 6'h08, 6'h23, 6'h2B, 6'h04})) begin
      fault_tail(3);
      return;
    end

    s = '0;
    case (op)
      6'h00: s.fn = ins[5:0];
      6'h04: begin s.fn = 6'b100010; s.pcs = 2'd1; s.pcw = z; end
      default: begin s.as = 1'b1; s.fn = 6'b100000; end
    endcase
    cyc(1'b0, rb(), z, $urandom, s);
    if (op == 6'h04) begin ret_m++; return; end

    if (op == 6'h23 || op == 6'h2B) begin
      s = '0; s.iord = 1'b1; s.as = 1'b1; s.fn = 6'b100000;
      s.mr = (op == 6'h23); s.mw = (op == 6'h2B);
      for (int i = 0; i < mw && i < TMO; i++) cyc(1'b0, 1'b0, rb(), $urandom, s);
      if (rst_mem) begin do_reset(); return; end
      if (mw >= TMO) begin fault_tail(3); return; end
      cyc(1'b0, 1'b1, rb(), $urandom, s);
      if (op == 6'h2B) begin ret_m++; return; end
    end

    s = '0; s.rw = 1'b1; s.rd = (op == 6'h00); s.m2r = (op == 6'h23);
    cyc(1'b0, rb(), rb(), $urandom, s);
    ret_m++;
  endtask

  initial begin
    logic [5:0]  ops [6];
    logic [5:0]  op;
    logic [25:0] lo;
    int fw, mw;
    ops[0] = 6'h00; ops[1] = 6'h08; ops[2] = 6'h23;
    ops[3] = 6'h2B; ops[4] = 6'h04; ops[5] = 6'h02;
    reset = 1'b1; mem_ready = 1'b0; zero = 1'b0; mem_rdata = '0; ret_m = '0;
    @(posedge clk); #1;
    do_reset();

    run_instr(32'h012A4020, 0, 0, 1'b0, 1'b0);   // ADD
    run_instr(32'h8D280008, 0, 3, 1'b0, 1'b0);   // LW, 3 mem waits
    run_instr(32'h11090003, 0, 0, 1'b1, 1'b0);   // BEQ taken
    run_instr(32'h11090003, 0, 0, 1'b0, 1'b0);   // BEQ not taken
    run_instr(32'h08000010, 0, 0, 1'b0, 1'b0);   // J
    run_instr(32'hFC000000, 0, 0, 1'b0, 1'b0);   // illegal 0x3F
    run_instr(32'h012A4020, TMO, 0, 1'b0, 1'b0); // fetch timeout
    run_instr(32'h012A4020, 2, 0, 1'b0, 1'b0);   // fetch waits, no timeout
    run_instr(32'hAD280004, 1, 2, 1'b0, 1'b1);   // SW, reset mid-MEM
    run_instr(32'h8D280008, 0, TMO, 1'b0, 1'b0); // mem timeout
    run_instr(32'hAD280004, 0, TMO - 1, 1'b0, 1'b0);

    for (int n = 0; n < 160; n++) begin
      if ($urandom_range(0, 19) == 0) begin
        do op = 6'($urandom_range(0, 63));
        while (op inside {6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h02});
      end else begin
        op = ops[$urandom_range(0, 5)];
      end
      lo = 26'($urandom);
      fw = ($urandom_range(0, 24) == 0) ? TMO : $urandom_range(0, TMO - 1);
      mw = ($urandom_range(0, 24) == 0) ? TMO : $urandom_range(0, TMO - 1);
      run_instr({op, lo}, fw, mw, rb(), ($urandom_range(0, 29) == 0));
    end

    @(negedge clk); #1;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
